irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Wishbone-slave external interrupt controller on the peripheral crossbar (new slot PERIPH_XBAR_IRQ_CTRL_SLAVE_IDX).
- Inputs are the peripheral interrupt lines (wbuart rx, tx, rxfifo and txfifo). Its registered output drives core_top.irq_external_i, replacing the constant-zero tie-off.
- Per source: enable, level or edge mode, and pending capture. Firmware claims interrupts and signals completion through a claim/complete register.

Parameters:
- NUM_SOURCES, 4, number of interrupt inputs (1..31); source i has ID i+1, and ID 0 means "none".

Ports:
- clk_i  input  1  core clock
- rstn_i  input  1  reset; asynchronous, active-low
- wb_if  slave  wishbone_if (PERIPH_WB_AW/PERIPH_WB_DW=32)  register access
- irq_src_i  input  NUM_SOURCES  raw interrupt lines, active-high, bit i = source ID i+1
- irq_o  output  1  external interrupt request to the core

Behaviour:
- Register map, word index addr[2:0]:
  - 0 PENDING: read-only; writes are ignored.
  - 1 ENABLE: read/write.
  - 2 EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - 3 CLAIM/COMPLETE.
  - Indices 4..7: read 0, writes ignored, always acked.
  - Bits at or above NUM_SOURCES read 0.
- Reset values:
  - PENDING, ENABLE, EDGE and the in-service mask (IS) are 0.
  - irq_o=0, ack=0, rdata=0.
  - stall=0, err=0 and rty=0 are constant.
- Wishbone:
  - Accept when cyc&stb; no stall.
  - ack is registered one cycle after accept; exactly one ack per accepted request; back-to-back requests give one ack per cycle.
  - ack is forced low in any cycle where cyc=0, so an aborted cycle produces no ack. Side effects of an already-accepted request still take place.
  - rdata is valid with ack.
  - ENABLE and EDGE writes are byte-masked by sel.
  - CLAIM/COMPLETE writes require sel[0]=1 and are otherwise ignored.
- Pending capture, per source, in each cycle:
  - Level mode: PENDING[i] = registered copy of the source.
  - Edge mode: PENDING[i] is set on a 0->1 transition of the source (previous-sample register), and cleared only by a claim of that ID.
  - Simultaneous edge and claim of the same source: the edge wins, so pending stays 1 and IS is set.
  - Changing EDGE from 1 to 0 makes the bit follow the source from the next cycle.
- Eligibility and irq_o:
  - eligible = PENDING & ENABLE & ~IS.
  - irq_o <= |eligible, registered.
  - Latency from the source rising to irq_o=1 is 2 cycles.
- Claim (read of index 3, at accept):
  - Returns the ID of the lowest-numbered eligible source, or 0 if none.
  - A nonzero result sets IS[id-1]; in edge mode it also clears PENDING[id-1].
  - A claim returning 0 has no side effects.
  - The IS update is visible to irq_o one cycle later.
- Complete (write of index 3):
  - wdata[4:0]=id clears IS[id-1] if it is set.
  - id=0, id>NUM_SOURCES, or a source not in service: ignored.
- Simultaneous complete and new edge on the same source: IS clears and pending is set; the source is eligible next cycle.
- Level source still high after complete: the source becomes eligible again.
- Reset asserted mid-transaction: all state returns to its reset values immediately; the in-flight request is dropped and no ack is issued.

Optional Feature:
- IRQ_CTRL_SYNC_EN
  - Defined: each irq_src_i bit passes through a 2-flop synchronizer, reset to 0, before capture. Source-to-irq_o latency becomes 4 cycles. Sources may be asynchronous.
  - Undefined: sources are sampled directly and must be synchronous to clk_i; latency is 2 cycles.

Decomposition:
- platform_pkg gains:
  - PERIPH_XBAR_IRQ_CTRL_SLAVE_IDX, with PERIPH_XBAR_NUM_SLAVES incremented and the address decode added.
  - IRQ_CTRL_NUM_SOURCES=4.
  - Register index constants IRQ_CTRL_PENDING_IDX, IRQ_CTRL_ENABLE_IDX, IRQ_CTRL_EDGE_IDX, IRQ_CTRL_CLAIM_IDX.
- Sub-module irq_gateway: one instance per source (generate loop). It contains the optional synchronizer, the previous-sample register and the pending flop. Its inputs are mode, claim_clear and src; its output is pending.
- The priority encoder, register file, IS mask and wishbone logic stay in irq_ctrl.

Test Plan:
- After reset: read indices 0..7 -> all return 0, irq_o=0; write index 0 = 0xF -> reads back 0.
- Level: ENABLE=0x1, EDGE=0, raise src[0] at cycle n:
  - irq_o=1 at n+2.
  - CLAIM returns 1 and irq_o=0 the cycle after the ack.
  - Complete with 1 while src[0] is still high -> irq_o=1 again two cycles later.
- Edge plus priority: EDGE=0xF, ENABLE=0xF, pulse src[2] and src[1] for 1 cycle together, then drop both:
  - PENDING=0x6.
  - Claims return 2, then 3, then 0.
  - Completes of 2 and 3 leave irq_o=0.
- Masking and bogus completes:
  - ENABLE=0, src[3] pulsed in edge mode -> PENDING=0x8, irq_o stays 0.
  - Set ENABLE=0x8 -> irq_o=1; claim returns 4.
  - Complete with 0, then 7 -> IS unchanged, irq_o stays 0.
- Edge collides with claim: new src[0] rising edge in the same cycle as the claim of ID 1 -> PENDING[0] stays 1; after complete 1, irq_o=1 two cycles later.
- Bus protocol:
  - Back-to-back reads of indices 1, 2, 3 -> three acks on consecutive cycles.
  - cyc dropped the cycle after a stb -> no ack.
  - rstn_i pulsed while a CLAIM is in flight -> no ack, all registers 0.
  - With IRQ_CTRL_SYNC_EN: source-to-irq_o latency is 4 cycles.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the external interrupt controller: source count,
// peripheral bus widths, register word indices and a byte-lane mask helper.
// Optional build macro used by this block: IRQ_CTRL_SYNC_EN (input synchronizers).
package irq_ctrl_pkg;

    localparam int IRQ_CTRL_NUM_SOURCES = 4;

    localparam int PERIPH_WB_AW = 32;
    localparam int PERIPH_WB_DW = 32;

    localparam logic [2:0] IRQ_CTRL_PENDING_IDX = 3'd0;
    localparam logic [2:0] IRQ_CTRL_ENABLE_IDX  = 3'd1;
    localparam logic [2:0] IRQ_CTRL_EDGE_IDX    = 3'd2;
    localparam logic [2:0] IRQ_CTRL_CLAIM_IDX   = 3'd3;

    // Expand the four byte selects into a 32-bit write mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: optional 2-flop synchronizer, previous-sample
// register and pending flop (level: follows source; edge: set on rise, cleared by claim).
// Build macro IRQ_CTRL_SYNC_EN adds the synchronizer (+2 cycles of latency).
module irq_gateway (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic mode,
    input  logic claim_clear,
    input  logic src,
    output logic pending
);

    logic src_s;
    logic prev_q;
    logic pending_q;

`ifdef IRQ_CTRL_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer so the source may be asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], src};
        end
    end

    assign src_s = sync_q[1];
`else
    assign src_s = src;
`endif

    // Edge mode: a new rising edge wins over a claim in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q <= src_s;
            if (mode) begin
                pending_q <= (src_s & ~prev_q) | (pending_q & ~claim_clear);
            end else begin
                pending_q <= src_s;
            end
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/irq_ctrl.sv
// Wishbone-slave external interrupt controller with per-source enable, edge/level
// mode, claim/complete and in-service masking; ack one cycle after accept, never stalls.
// Build macro IRQ_CTRL_SYNC_EN: source-to-irq_o latency 4 cycles instead of 2.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES = IRQ_CTRL_NUM_SOURCES
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wb_cyc,
    input  logic                      wb_stb,
    input  logic                      wb_we,
    input  logic [PERIPH_WB_AW-1:0]   wb_adr,
    input  logic [PERIPH_WB_DW-1:0]   wb_dat_w,
    input  logic [PERIPH_WB_DW/8-1:0] wb_sel,
    output logic [PERIPH_WB_DW-1:0]   wb_dat_r,
    output logic                      wb_ack,
    output logic                      wb_stall,
    output logic                      wb_err,
    output logic                      wb_rty,
    input  logic [NUM_SOURCES-1:0]    irq_src_i,
    output logic                      irq_o
);

    logic                    accept;
    logic [2:0]              idx;
    logic [31:0]             wr_mask;
    logic [NUM_SOURCES-1:0]  pending;
    logic [NUM_SOURCES-1:0]  enable_q, enable_d;
    logic [NUM_SOURCES-1:0]  edge_q, edge_d;
    logic [NUM_SOURCES-1:0]  is_q, is_d;
    logic [NUM_SOURCES-1:0]  eligible;
    logic [NUM_SOURCES-1:0]  lowest;
    logic [NUM_SOURCES-1:0]  claim_clear;
    logic [NUM_SOURCES-1:0]  cmp_mask;
    logic [4:0]              claim_id;
    logic                    claim_rd;
    logic                    cmp_wr;
    logic [PERIPH_WB_DW-1:0] rd_data;
    logic                    ack_q;
    logic [PERIPH_WB_DW-1:0] dat_r_q;
    logic                    irq_q;
    logic                    unused_bits;

    assign accept   = wb_cyc & wb_stb;
    assign idx      = wb_adr[2:0];
    assign wr_mask  = sel_to_mask(wb_sel);
    assign claim_rd = accept & ~wb_we & (idx == IRQ_CTRL_CLAIM_IDX);
    assign cmp_wr   = accept & wb_we & (idx == IRQ_CTRL_CLAIM_IDX) & wb_sel[0];

    assign eligible = pending & enable_q & ~is_q;
    // Isolate the lowest set bit: that is the source a claim hands out.
    assign lowest      = eligible & (-eligible);
    assign claim_clear = claim_rd ? lowest : '0;

    genvar g;
    generate
        for (g = 0; g < NUM_SOURCES; g++) begin : g_gw
            irq_gateway u_gw (
                .clk_i       (clk_i),
                .rstn_i      (rstn_i),
                .mode        (edge_q[g]),
                .claim_clear (claim_clear[g]),
                .src         (irq_src_i[g]),
                .pending     (pending[g])
            );
        end
    endgenerate

    // Priority encode the lowest-numbered eligible source into its ID (0 = none).
    always_comb begin
        claim_id = 5'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                claim_id = 5'(i + 1);
            end
        end
    end

    // Next-state of ENABLE, EDGE and the in-service mask from bus writes and claims.
    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        cmp_mask = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cmp_mask[i] = cmp_wr & (wb_dat_w[4:0] == 5'(i + 1));
            if (accept && wb_we && idx == IRQ_CTRL_ENABLE_IDX && wr_mask[i]) begin
                enable_d[i] = wb_dat_w[i];
            end
            if (accept && wb_we && idx == IRQ_CTRL_EDGE_IDX && wr_mask[i]) begin
                edge_d[i] = wb_dat_w[i];
            end
        end
        is_d = (is_q | claim_clear) & ~cmp_mask;
    end

    // Read mux; unimplemented indices and bits above NUM_SOURCES read as zero.
    always_comb begin
        rd_data = '0;
        case (idx)
            IRQ_CTRL_PENDING_IDX: rd_data = {{(PERIPH_WB_DW - NUM_SOURCES){1'b0}}, pending};
            IRQ_CTRL_ENABLE_IDX:  rd_data = {{(PERIPH_WB_DW - NUM_SOURCES){1'b0}}, enable_q};
            IRQ_CTRL_EDGE_IDX:    rd_data = {{(PERIPH_WB_DW - NUM_SOURCES){1'b0}}, edge_q};
            IRQ_CTRL_CLAIM_IDX:   rd_data = {{(PERIPH_WB_DW - 5){1'b0}}, claim_id};
            default:              rd_data = '0;
        endcase
    end

    // Register state, the bus response and the interrupt request.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            enable_q <= '0;
            edge_q   <= '0;
            is_q     <= '0;
            ack_q    <= 1'b0;
            dat_r_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            edge_q   <= edge_d;
            is_q     <= is_d;
            ack_q    <= accept;
            dat_r_q  <= (accept && !wb_we) ? rd_data : '0;
            irq_q    <= |eligible;
        end
    end

    // An aborted cycle (cyc dropped) must never see the pending ack.
    assign wb_ack   = ack_q & wb_cyc;
    assign wb_dat_r = dat_r_q;
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;
    assign wb_rty   = 1'b0;
    assign irq_o    = irq_q;

    assign unused_bits = ^{wb_adr[PERIPH_WB_AW-1:3], wb_dat_w[PERIPH_WB_DW-1:NUM_SOURCES],
                           wr_mask[31:NUM_SOURCES]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: bus requests push expected read data into a
// scoreboard queue, a negedge monitor pops and compares on every ack.
// irq_o is checked inline at hand-computed cycles.
module tb_irq_ctrl;

    localparam int N = 4;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT = SD + 2;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_stall, wb_err, wb_rty;
    logic [N-1:0] irq_src_i;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    irq_ctrl #(.NUM_SOURCES(N)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_sel    (wb_sel),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall),
        .wb_err    (wb_err),
        .wb_rty    (wb_rty),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ack_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data.
    always @(negedge clk_i) begin
        exp_t e;
        if (wb_ack === 1'b1) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: ack=1 with nothing outstanding, expected ack=0");
            end else begin
                e = sb.pop_front();
                if (e.is_read) check(e.name, wb_dat_r, e.dat);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_exp(input logic is_read, input int idx, input logic [31:0] dat);
        exp_t e;
        e.is_read = is_read;
        e.dat     = dat;
        e.name    = $sformatf("rd_idx%0d", idx);
        sb.push_back(e);
    endtask

    task automatic bus(input logic we, input int idx, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rd);
        push_exp(!we, idx, exp_rd);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = 32'(idx);
        wb_dat_w = dat;
        wb_sel   = sel;
        tick(1);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        tick(1);
        wb_cyc = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp_rd);
        bus(1'b0, idx, 32'h0, 4'hF, exp_rd);
    endtask

    task automatic wr(input int idx, input logic [31:0] dat, input logic [3:0] sel);
        bus(1'b1, idx, dat, sel, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rstn_i = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        irq_src_i = '0;
        tick(3);
        check("reset_irq", 32'(irq_o), 32'h0);
        check("reset_ack", 32'(wb_ack), 32'h0);
        check("reset_rdata", wb_dat_r, 32'h0);
        check("const_stall_err_rty", 32'({wb_stall, wb_err, wb_rty}), 32'h0);
        rstn_i = 1'b1;
        tick(1);

        // Everything reads zero after reset; PENDING ignores writes.
        for (int i = 0; i < 8; i++) rd(i, 32'h0);
        check("reset_irq_after_reads", 32'(irq_o), 32'h0);
        wr(0, 32'hF, 4'hF);
        rd(0, 32'h0);

        // Level mode on source 0.
        wr(1, 32'h1, 4'hF);
        wr(2, 32'h0, 4'hF);
        irq_src_i[0] = 1'b1;
        tick(LAT - 1);
        check("level_irq_early", 32'(irq_o), 32'h0);
        tick(1);
        check("level_irq_rise", 32'(irq_o), 32'h1);
        rd(3, 32'h1);
        check("level_irq_after_claim", 32'(irq_o), 32'h0);
        wr(3, 32'h1, 4'hF);
        check("level_irq_after_complete", 32'(irq_o), 32'h1);
        irq_src_i[0] = 1'b0;
        tick(LAT + 1);
        check("level_irq_drop", 32'(irq_o), 32'h0);

        // Edge mode, two simultaneous pulses, priority order.
        wr(2, 32'hF, 4'hF);
        wr(1, 32'hF, 4'hF);
        irq_src_i = 4'b0110;
        tick(1);
        irq_src_i = 4'b0000;
        tick(LAT + 1);
        rd(0, 32'h6);
        check("edge_irq", 32'(irq_o), 32'h1);
        rd(3, 32'h2);
        rd(3, 32'h3);
        check("edge_irq_all_claimed", 32'(irq_o), 32'h0);
        rd(3, 32'h0);
        wr(3, 32'h2, 4'hF);
        wr(3, 32'h3, 4'hF);
        tick(1);
        check("edge_irq_after_completes", 32'(irq_o), 32'h0);
        rd(0, 32'h0);

        // Masking and bogus completes on source 3 (ID 4).
        wr(1, 32'h0, 4'hF);
        irq_src_i[3] = 1'b1;
        tick(1);
        irq_src_i[3] = 1'b0;
        tick(LAT + 1);
        rd(0, 32'h8);
        check("masked_irq", 32'(irq_o), 32'h0);
        wr(1, 32'h8, 4'hF);
        check("unmasked_irq", 32'(irq_o), 32'h1);
        rd(3, 32'h4);
        check("claim4_irq", 32'(irq_o), 32'h0);
        wr(3, 32'h0, 4'hF);
        wr(3, 32'h7, 4'hF);
        wr(3, 32'h4, 4'hE);
        irq_src_i[3] = 1'b1;
        tick(1);
        irq_src_i[3] = 1'b0;
        tick(LAT + 1);
        rd(0, 32'h8);
        check("bogus_complete_irq", 32'(irq_o), 32'h0);
        wr(3, 32'h4, 4'hF);
        check("complete4_irq", 32'(irq_o), 32'h1);
        rd(3, 32'h4);
        wr(3, 32'h4, 4'hF);

        // New edge on source 0 lands in the same cycle as its claim.
        wr(1, 32'h1, 4'hF);
        irq_src_i[0] = 1'b1;
        tick(1);
        irq_src_i[0] = 1'b0;
        tick(LAT + 1);
        check("collide_irq_pre", 32'(irq_o), 32'h1);
        irq_src_i[0] = 1'b1;
        tick(SD);
        rd(3, 32'h1);
        check("collide_irq_after_claim", 32'(irq_o), 32'h0);
        rd(0, 32'h1);
        wr(3, 32'h1, 4'hF);
        check("collide_irq_after_complete", 32'(irq_o), 32'h1);
        irq_src_i[0] = 1'b0;
        rd(3, 32'h1);
        wr(3, 32'h1, 4'hF);

        // Back-to-back reads: one ack per cycle.
        a0 = ack_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        push_exp(1'b1, 1, 32'h1); wb_adr = 32'd1; tick(1);
        push_exp(1'b1, 2, 32'hF); wb_adr = 32'd2; tick(1);
        push_exp(1'b1, 3, 32'h0); wb_adr = 32'd3; tick(1);
        wb_stb = 1'b0;
        tick(1);
        wb_cyc = 1'b0;
        check("b2b_ack_count", 32'(ack_cnt - a0), 32'd3);

        // Aborted write: no ack, but the write still lands.
        a0 = ack_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'd1;
        wb_dat_w = 32'h5; wb_sel = 4'hF;
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick(3);
        check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        rd(1, 32'h5);

        // Reset pulse while a claim of ID 3 is in flight.
        irq_src_i[2] = 1'b1;
        tick(1);
        irq_src_i[2] = 1'b0;
        tick(LAT + 1);
        check("rst_pre_irq", 32'(irq_o), 32'h1);
        a0 = ack_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd3;
        tick(1);
        rstn_i = 1'b0;
        wb_stb = 1'b0;
        tick(1);
        wb_cyc = 1'b0;
        tick(1);
        rstn_i = 1'b1;
        tick(1);
        check("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("rst_irq", 32'(irq_o), 32'h0);
        rd(0, 32'h0);
        rd(1, 32'h0);
        rd(2, 32'h0);
        wr(1, 32'h4, 4'hF);
        irq_src_i[2] = 1'b1;
        tick(LAT);
        check("rst_is_cleared_irq", 32'(irq_o), 32'h1);
        rd(3, 32'h3);
        irq_src_i[2] = 1'b0;

        tick(2);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
